// File: rtl/toggle_pkg.sv
// Shared definitions for the toggle-encoded handshake blocks: FSM state
// encodings and the default data/counter widths.
package toggle_pkg;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 16;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;

endpackage

// File: rtl/toggle_edge_sync.sv
// Synchronises a toggle-encoded level into the local clock domain and turns
// each level inversion into a single-cycle event. The matching transmitter
// uses the same block to detect ack toggles.
module toggle_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic lvl_i,
    output logic ev_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Shift the level through the synchroniser and remember the last synchronised value
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q[0] <= lvl_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign ev_o = sync_q[SYNC_STAGES-1] ^ prev_q;

endmodule

// File: rtl/toggle_rx.sv
// Receiver for the toggle-encoded handshake. Each req toggle captures one
// data word, presents it on a valid/ready port and, once accepted, inverts
// the ack level back to the sender. Counts completed transfers and raises a
// sticky overrun flag if req toggles while a transfer is still outstanding.
module toggle_rx #(
    parameter int DATA_W      = toggle_pkg::DATA_W,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = toggle_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              ack,
    output logic [CNT_W-1:0]  xfer_cnt,
    output logic              overrun
);

    import toggle_pkg::*;

    logic              ev;
    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              ack_q, ack_d;
    logic              ovr_q, ovr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    toggle_edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_edge_sync (
        .clk_i(clk),
        .rst_i(reset),
        .lvl_i(req),
        .ev_o (ev)
    );

    // Next-state logic: capture in IDLE, wait for the consumer in HOLD, toggle ack in ACK
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        valid_d = valid_q;
        ack_d   = ack_q;
        ovr_d   = ovr_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (ev) begin
                    data_d  = data_in;
                    valid_d = 1'b1;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (ev) begin
                    ovr_d = 1'b1;
                end
                if (valid_q && out_ready) begin
                    valid_d = 1'b0;
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                if (ev) begin
                    ovr_d = 1'b1;
                end
                ack_d   = ~ack_q;
                cnt_d   = cnt_q + 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, holding register, ack level, counter and sticky overrun flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            valid_q <= 1'b0;
            ack_q   <= 1'b0;
            ovr_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ack_q   <= ack_d;
            ovr_q   <= ovr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign ack       = ack_q;
    assign xfer_cnt  = cnt_q;
    assign overrun   = ovr_q;

endmodule
